// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID-side instruction fields, hazard controls,
// EX/MEM and MEM/WB forwarding buses, and the EX-side outputs to the ALU.
// The stage itself is the slave; whoever drives ID and the result buses is the master.
interface id_ex_operand_stage_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  // hazard / branch control
  logic          stall;
  logic          flush;
  // decoded instruction from ID
  logic          id_valid;
  logic [2:0]    id_op;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [AW-1:0] id_rd_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  // forwarding sources
  logic          exm_reg_write;
  logic [AW-1:0] exm_rd_addr;
  logic [DW-1:0] exm_result;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd_addr;
  logic [DW-1:0] wb_result;
  // EX stage outputs
  logic          ex_valid;
  logic [1:0]    ALUctl;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic          illegal_op;

  modport master (
    output stall, flush, id_valid, id_op, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, exm_reg_write, exm_rd_addr,
           exm_result, wb_reg_write, wb_rd_addr, wb_result,
    input  ex_valid, ALUctl, A, B, ex_rd_addr, ex_reg_write, illegal_op
  );

  modport slave (
    input  stall, flush, id_valid, id_op, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, exm_reg_write, exm_rd_addr,
           exm_result, wb_reg_write, wb_rd_addr, wb_result,
    output ex_valid, ALUctl, A, B, ex_rd_addr, ex_reg_write, illegal_op
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU. Captures decoded fields and
// register-file operands, decodes op into ALUctl, and forwards EX/MEM or
// MEM/WB results into the A/B operands. Priority at the clock edge is
// flush > stall > capture.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// fields on every non-stalled, non-flushed edge; stall holds the stage (the
// upstream must hold ID too); flush turns the next EX contents into a bubble.
module id_ex_operand_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  id_ex_operand_stage_if.slave io
);

  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SLTI = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // EX stage state
  logic          valid_q;
  logic          reg_write_q;
  logic          illegal_q;
  logic [1:0]    aluctl_q;
  logic          use_imm_q;
  logic [AW-1:0] rs_addr_q;
  logic [AW-1:0] rt_addr_q;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;

  // decode of the incoming ID op
  logic [1:0]    dec_aluctl;
  logic          dec_use_imm;
  logic          dec_writes;
  logic          dec_illegal;

  // forwarded operands
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Decode op into ALU control, B-source select and register-write intent.
  always_comb begin
    dec_aluctl  = 2'd0;
    dec_use_imm = 1'b0;
    dec_writes  = 1'b1;
    dec_illegal = 1'b0;
    case (io.id_op)
      3'd0, 3'd1, 3'd2, 3'd3: dec_aluctl = io.id_op[1:0];
      OP_ADDI: dec_use_imm = 1'b1;
      OP_SLTI: begin
        dec_aluctl  = 2'd2;
        dec_use_imm = 1'b1;
      end
      OP_NOP:  dec_writes = 1'b0;
      OP_ILL: begin
        dec_writes  = 1'b0;
        dec_illegal = 1'b1;
      end
      default: dec_aluctl = 2'd0;
    endcase
  end

  // Forward from EX/MEM first, then MEM/WB; r0 always reads as zero.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (rs_addr_q == '0)
      fwd_rs = '0;
    else if (io.exm_reg_write && (io.exm_rd_addr == rs_addr_q))
      fwd_rs = io.exm_result;
    else if (io.wb_reg_write && (io.wb_rd_addr == rs_addr_q))
      fwd_rs = io.wb_result;

    if (rt_addr_q == '0)
      fwd_rt = '0;
    else if (io.exm_reg_write && (io.exm_rd_addr == rt_addr_q))
      fwd_rt = io.exm_result;
    else if (io.wb_reg_write && (io.wb_rd_addr == rt_addr_q))
      fwd_rt = io.wb_result;
  end

  // Pipeline register: flush makes a bubble, stall holds control but refreshes
  // operands from the forwarding mux so a producer retiring now is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      aluctl_q    <= 2'd0;
      use_imm_q   <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
    end else if (io.flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (io.stall) begin
      rs_data_q   <= fwd_rs;
      rt_data_q   <= fwd_rt;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= io.id_valid && !dec_illegal;
      reg_write_q <= io.id_valid && dec_writes && (io.id_rd_addr != '0);
      illegal_q   <= io.id_valid && dec_illegal;
      aluctl_q    <= dec_aluctl;
      use_imm_q   <= dec_use_imm;
      rs_addr_q   <= io.id_rs_addr;
      rt_addr_q   <= io.id_rt_addr;
      rd_addr_q   <= io.id_rd_addr;
      rs_data_q   <= io.id_rs_data;
      rt_data_q   <= io.id_rt_data;
      imm_q       <= io.id_imm;
    end
  end

  // Outputs toward the ALU and the rest of the pipe.
  always_comb begin
    io.ex_valid     = valid_q;
    io.ex_reg_write = reg_write_q;
    io.illegal_op   = illegal_q;
    io.ALUctl       = aluctl_q;
    io.ex_rd_addr   = rd_addr_q;
    io.A            = fwd_rs;
    io.B            = use_imm_q ? imm_q : fwd_rt;
  end

endmodule
